// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_arith_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             iSTART;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic [WIDTH-1:0] oDIFF;
    logic             oBORROW;
    logic             oBUSY;
    logic             oDONE;

    modport master (
        output iSTART, iA, iB,
        input  oDIFF, oBORROW, oBUSY, oDONE
    );

    modport slave (
        input  iSTART, iA, iB,
        output oDIFF, oBORROW, oBUSY, oDONE
    );

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full-subtractor cell
module full_subtractor (
    input  logic iX,
    input  logic iY,
    input  logic iBIN,
    output logic oDIFF,
    output logic oBOUT
);

    assign oDIFF = iX ^ iY ^ iBIN;
    assign oBOUT = (~iX & iY) | (~(iX ^ iY) & iBIN);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B, LSB first, one bit per clock behind start/busy/done
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                iCLK,
    input  logic                iRST,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bin_q, bin_d;

    logic               cell_diff;
    logic               cell_bout;

    full_subtractor u_cell (
        .iX    (a_q[0]),
        .iY    (b_q[0]),
        .iBIN  (bin_q),
        .oDIFF (cell_diff),
        .oBOUT (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (bus.iSTART) begin
                    a_d     = bus.iA;
                    b_d     = bus.iB;
                    diff_d  = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Result fills from the top so the LSB lands at bit 0 after WIDTH shifts.
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {cell_diff, diff_q[WIDTH-1:1]};
                bin_d  = cell_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bin_q   <= bin_d;
        end
    end

    // The borrow flop is only reloaded on an accepted start, so it doubles as the held borrow-out.
    assign bus.oDIFF   = diff_q;
    assign bus.oBORROW = bin_q;
    assign bus.oBUSY   = (state_q == SHIFT);
    assign bus.oDONE   = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8 and 4
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; optionally pulses a stray start k samples after acceptance.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int intrude_at, input string tag);
        int         busy_n;
        int         lat;
        int         dones;
        logic [7:0] ed;
        logic       eb;
        busy_n = 0;
        lat    = 0;
        dones  = 0;
        ed     = a - b;
        eb     = (a < b);
        @(negedge clk);
        bus8.iSTART = 1'b1;
        bus8.iA     = a;
        bus8.iB     = b;
        @(posedge clk);
        #1;
        bus8.iSTART = 1'b0;
        bus8.iA     = 8'($urandom);
        bus8.iB     = 8'($urandom);
        for (int k = 1; k <= 14; k++) begin
            if (bus8.oBUSY) busy_n++;
            if (bus8.oDONE) begin
                dones++;
                if (lat == 0) begin
                    lat = k;
                    check({tag, " diff"}, 32'(bus8.oDIFF), 32'(ed));
                    check({tag, " borrow"}, 32'(bus8.oBORROW), 32'(eb));
                end
            end
            if (k == intrude_at) begin
                bus8.iSTART = 1'b1;
                bus8.iA     = 8'd1;
                bus8.iB     = 8'd1;
            end
            @(posedge clk);
            #1;
            bus8.iSTART = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " busy cycles"}, 32'(busy_n), 32'd8);
        check({tag, " done pulses"}, 32'(dones), 32'd1);
        check({tag, " diff held"}, 32'(bus8.oDIFF), 32'(ed));
        check({tag, " borrow held"}, 32'(bus8.oBORROW), 32'(eb));
    endtask

    initial begin
        int         dones;
        logic [3:0] a4, b4, e4;

        bus8.iSTART = 1'b0;
        bus8.iA     = '0;
        bus8.iB     = '0;
        bus4.iSTART = 1'b0;
        bus4.iA     = '0;
        bus4.iB     = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst diff", 32'(bus8.oDIFF), 32'd0);
        check("rst borrow", 32'(bus8.oBORROW), 32'd0);
        check("rst busy", 32'(bus8.oBUSY), 32'd0);
        check("rst done", 32'(bus8.oDONE), 32'd0);
        check("rst diff4", 32'(bus4.oDIFF), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op8(8'd100, 8'd37, 0, "basic");
        op8(8'd5, 8'd9, 0, "underflow");
        op8(8'h00, 8'h00, 0, "zero");
        op8(8'hFF, 8'h01, 0, "ff-1");
        op8(8'h00, 8'hFF, 0, "0-ff");
        op8(8'h80, 8'h01, 0, "80-1");
        op8(8'd50, 8'd20, 3, "start while busy");
        repeat (5) @(posedge clk);
        #1;
        check("hold after idle diff", 32'(bus8.oDIFF), 32'd30);
        check("hold after idle borrow", 32'(bus8.oBORROW), 32'd0);

        // Reset during the 4th shift cycle must clear everything and suppress oDONE.
        @(negedge clk);
        bus8.iSTART = 1'b1;
        bus8.iA     = 8'd200;
        bus8.iB     = 8'd13;
        @(posedge clk);
        #1;
        bus8.iSTART = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst diff", 32'(bus8.oDIFF), 32'd0);
        check("midrst borrow", 32'(bus8.oBORROW), 32'd0);
        check("midrst busy", 32'(bus8.oBUSY), 32'd0);
        check("midrst done", 32'(bus8.oDONE), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus8.oDONE) dones++;
        end
        check("midrst no done", 32'(dones), 32'd0);
        op8(8'd7, 8'd3, 0, "after reset");

        for (int r = 0; r < 25; r++) begin
            op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 9)), "random");
        end

        // All 4-bit pairs back-to-back at the minimum issue interval.
        for (int i = 0; i < 256; i++) begin
            a4 = i[7:4];
            b4 = i[3:0];
            e4 = a4 - b4;
            @(negedge clk);
            bus4.iSTART = 1'b1;
            bus4.iA     = a4;
            bus4.iB     = b4;
            @(posedge clk);
            #1;
            bus4.iSTART = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("w4 done", 32'(bus4.oDONE), 32'd1);
            check("w4 diff", 32'(bus4.oDIFF), 32'(e4));
            check("w4 borrow", 32'(bus4.oBORROW), 32'(a4 < b4));
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
